cdc_2phase_rr_mux: RTL and testbench
====================================

// Module: cdc_2phase_rr_mux
// PURPOSE
// Source-domain scheduler sharing one cdc_2phase source port between NumIn valid/ready requesters.
// Round-robin arbitration; grant frozen while a beat waits (CDC stability); optional bursts per grant.
// Output carries the winning requester index next to the data so the destination side can demux.
// Sits directly in front of the CDC source port; zero-latency combinational datapath, registered grant state.
// PARAMETERS
// NumIn      4    number of requesters (>=1)
// DataWidth  32   payload width
// MaxBurst   1    max consecutive beats per grant before forced rotation (>=1)
// CntWidth   16   width of transfer statistics counter
// IdxWidth   $clog2(NumIn) (1 if NumIn==1), derived, not overridable
// PORTS
// clk_i        in   1                   clock, all logic on rising edge
// rst_ni       in   1                   reset, asynchronous, active-low
// flush_i      in   1                   synchronous clear of arbitration state
// in_data_i    in   NumIn x DataWidth   requester payloads
// in_valid_i   in   NumIn               requester valid
// in_ready_o   out  NumIn               requester ready
// out_data_o   out  DataWidth           payload to CDC source
// out_idx_o    out  IdxWidth            index of granted requester
// out_valid_o  out  1                   valid to CDC source
// out_ready_i  in   1                   ready from CDC source
// busy_o       out  1                   state != IDLE
// xfer_cnt_o   out  CntWidth            accepted output beats, wraps modulo 2^CntWidth
// BEHAVIOUR
// - Reset (rst_ni=0): state=IDLE, rr_q=0, gnt_q=0, burst_q=0, xfer_cnt_o=0; busy_o=0.
// - State: IDLE | HOLD | BURST. HOLD/BURST use stored gnt_q; IDLE picks a fresh winner.
// - IDLE winner: first i with in_valid_i[i]=1 scanning rr_q, rr_q+1, ... modulo NumIn.
// - out_valid_o = in_valid_i[winner]; out_data_o/out_idx_o = winner's data/index (idx=0 if none valid).
// - in_ready_o[i] = out_ready_i & out_valid_o & (i==winner) & ~flush_i; all others 0. Handshake hs = out_valid_o & out_ready_i & ~flush_i.
// - IDLE: valid & ~hs -> HOLD, gnt_q=winner. hs -> see ACCEPT.
// - HOLD: winner=gnt_q regardless of other valids; requester must keep valid/data stable (assert).
//   hs -> ACCEPT.
// - ACCEPT (on hs): xfer_cnt+1; if burst_q+1 < MaxBurst -> BURST, gnt_q=winner, burst_q+1;
//   else -> IDLE, rr_q=(winner+1) mod NumIn, burst_q=0.
// - BURST: if in_valid_i[gnt_q]=1, winner=gnt_q (other requesters stall), same rules as HOLD/ACCEPT
//   (valid & ~hs stays BURST with grant frozen). If in_valid_i[gnt_q]=0, burst ends same cycle:
//   rr_q=(gnt_q+1) mod NumIn used combinationally, IDLE arbitration applies this cycle, burst_q=0.
// - MaxBurst=1: BURST never entered; strict one-beat round robin.
// - NumIn=1: winner always 0, rr_q constant 0.
// - Wrap: rr_q from NumIn-1 wraps to 0; xfer_cnt_o wraps 2^CntWidth-1 -> 0, no flag.
// - flush_i=1 (priority over everything): out_valid_o=0, all in_ready_o=0, no hs, no count;
//   next state IDLE, rr_q=0, burst_q=0, xfer_cnt_o=0. Caller only flushes with CDC source idle/cleared.
// - Reset mid-HOLD/BURST: immediate return to reset values; in-flight beat is not transferred.
// - out_ready_i may toggle freely; dropping it never releases a frozen grant.
// TESTING
// 1 Reset, NumIn=4, all valid=1, out_ready=1 held: out_idx sequence 0,1,2,3,0,...; xfer_cnt=N after N beats.
// 2 Hold: req0,req2 valid, out_ready=0 for 5 cycles -> out_idx=0 stable, busy_o=1; then out_ready=1 -> idx0 then idx2.
// 3 MaxBurst=3, all valid, out_ready=1 -> idx 0,0,0,1,1,1,2,2,2; req1 drops valid after 1 beat -> burst ends, next idx 2.
// 4 Flush while HOLD on idx 2 -> same cycle out_valid=0, in_ready=0; next cycle rr_q=0, xfer_cnt=0, busy_o=0.
// 5 CntWidth=4: 17 accepted beats -> xfer_cnt_o=1; NumIn=1 -> out_idx always 0, pass-through handshake.
// 6 Async reset asserted mid-BURST between clock edges -> state/outputs reset without clock edge.

Source files
------------

// File: rtl/cdc_2phase_rr_mux.sv
`default_nettype none
// cdc_2phase_rr_mux: round-robin valid/ready scheduler feeding a single CDC source port.
// Grant is frozen while a beat waits; optional multi-beat bursts per grant. Rev 1.0
module cdc_2phase_rr_mux #(
  parameter int  NumIn     = 4,
  parameter int  DataWidth = 32,
  parameter int  MaxBurst  = 1,
  parameter int  CntWidth  = 16,
  localparam int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NumIn*DataWidth-1:0] in_data_i,
  input  logic [NumIn-1:0]           in_valid_i,
  output logic [NumIn-1:0]           in_ready_o,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [IdxWidth-1:0]        out_idx_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic [CntWidth-1:0]        xfer_cnt_o
);

  localparam int BurstWidth = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
  localparam int IdxSpan    = 1 << IdxWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IdxWidth-1:0]   rr_q, rr_d;
  logic [IdxWidth-1:0]   gnt_q, gnt_d;
  logic [BurstWidth-1:0] burst_q, burst_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic [IdxSpan-1:0]    valid_pad;
  logic                  gnt_valid;
  logic                  burst_end;
  logic                  use_gnt;
  logic [IdxWidth-1:0]   rr_eff;
  logic [IdxWidth-1:0]   arb_idx;
  logic [IdxWidth-1:0]   winner;
  logic [BurstWidth-1:0] burst_eff;
  logic                  valid;
  logic                  hs;
  int                    scan_pos;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
    if (int'(i) >= NumIn - 1) return '0;
    else return i + IdxWidth'(1);
  endfunction

  // Padding to a power of two keeps every index select in range, including NumIn==1.
  assign valid_pad = IdxSpan'(in_valid_i);

  always_comb begin
    gnt_valid = valid_pad[gnt_q];
    burst_end = (state_q == BURST) && !gnt_valid;
    use_gnt   = (state_q == HOLD) || ((state_q == BURST) && gnt_valid);
    rr_eff    = burst_end ? next_idx(gnt_q) : rr_q;
    burst_eff = burst_end ? '0 : burst_q;
    // Descending scan so the candidate closest to rr_eff is written last and wins.
    arb_idx   = '0;
    scan_pos  = 0;
    for (int k = NumIn - 1; k >= 0; k--) begin
      scan_pos = int'(rr_eff) + k;
      if (scan_pos >= NumIn) scan_pos = scan_pos - NumIn;
      if (valid_pad[IdxWidth'(scan_pos)]) arb_idx = IdxWidth'(scan_pos);
    end
    winner = use_gnt ? gnt_q : arb_idx;
    valid  = !flush_i && valid_pad[winner];
    hs     = valid && out_ready_i;
  end

  always_comb begin
    out_data_o = '0;
    in_ready_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (winner == IdxWidth'(i)) begin
        out_data_o    = in_data_i[i*DataWidth +: DataWidth];
        in_ready_o[i] = hs;
      end
    end
  end

  assign out_idx_o   = winner;
  assign out_valid_o = valid;
  assign busy_o      = (state_q != IDLE);
  assign xfer_cnt_o  = cnt_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      rr_d    = '0;
      gnt_d   = '0;
      burst_d = '0;
      cnt_d   = '0;
    end else begin
      if (burst_end) begin
        state_d = IDLE;
        rr_d    = rr_eff;
        burst_d = '0;
      end
      if (hs) begin
        cnt_d = cnt_q + CntWidth'(1);
        if (int'(burst_eff) + 1 < MaxBurst) begin
          state_d = BURST;
          gnt_d   = winner;
          burst_d = burst_eff + BurstWidth'(1);
        end else begin
          state_d = IDLE;
          rr_d    = next_idx(winner);
          burst_d = '0;
        end
      end else if (valid && !use_gnt) begin
        state_d = HOLD;
        gnt_d   = winner;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A beat offered to the CDC source must not be withdrawn or altered before acceptance.
  hold_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    (state_q == HOLD) |-> gnt_valid);
  hold_data_a: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    (state_q == HOLD) |-> $stable(out_data_o));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdc_2phase_rr_mux.sv
`default_nettype none
// Bench for cdc_2phase_rr_mux: 4-way single-beat (4-bit counter), 4-way burst-of-3, and
// single-requester instances, with expected beats queued when stimulus is driven.
module tb_cdc_2phase_rr_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];

  logic         a_flush = 1'b0;
  logic [127:0] a_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  logic [3:0]   a_valid = '0;
  logic [3:0]   a_ready;
  logic [31:0]  a_odata;
  logic [1:0]   a_idx;
  logic         a_ovalid;
  logic         a_oready = 1'b0;
  logic         a_busy;
  logic [3:0]   a_cnt;

  logic         b_flush = 1'b0;
  logic [127:0] b_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  logic [3:0]   b_valid = '0;
  logic [3:0]   b_ready;
  logic [31:0]  b_odata;
  logic [1:0]   b_idx;
  logic         b_ovalid;
  logic         b_oready = 1'b0;
  logic         b_busy;
  logic [15:0]  b_cnt;

  logic         c_flush = 1'b0;
  logic [31:0]  c_data  = 32'hC00;
  logic         c_valid = 1'b0;
  logic         c_ready;
  logic [31:0]  c_odata;
  logic         c_idx;
  logic         c_ovalid;
  logic         c_oready = 1'b0;
  logic         c_busy;
  logic [15:0]  c_cnt;

  cdc_2phase_rr_mux #(.NumIn(4), .DataWidth(32), .MaxBurst(1), .CntWidth(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .in_data_i(a_data),
    .in_valid_i(a_valid), .in_ready_o(a_ready), .out_data_o(a_odata), .out_idx_o(a_idx),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready), .busy_o(a_busy), .xfer_cnt_o(a_cnt));

  cdc_2phase_rr_mux #(.NumIn(4), .DataWidth(32), .MaxBurst(3), .CntWidth(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .in_data_i(b_data),
    .in_valid_i(b_valid), .in_ready_o(b_ready), .out_data_o(b_odata), .out_idx_o(b_idx),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready), .busy_o(b_busy), .xfer_cnt_o(b_cnt));

  cdc_2phase_rr_mux #(.NumIn(1), .DataWidth(32), .MaxBurst(1), .CntWidth(16)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .in_data_i(c_data),
    .in_valid_i(c_valid), .in_ready_o(c_ready), .out_data_o(c_odata), .out_idx_o(c_idx),
    .out_valid_o(c_ovalid), .out_ready_i(c_oready), .busy_o(c_busy), .xfer_cnt_o(c_cnt));

  task automatic test_reset();
    a_valid = 4'hF;
    rst_n   = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else pass_cnt++;
    total_cnt++; if (a_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", a_cnt); else pass_cnt++;
    total_cnt++; if (a_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", a_idx); else pass_cnt++;
    total_cnt++; if (b_busy !== 1'b0) $display("FAIL reset_busy_b: got %b want 0", b_busy); else pass_cnt++;
    a_valid = 4'h0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int e;
    a_valid  = 4'hF;
    a_oready = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(k % 4);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (a_ovalid && a_oready) begin
        if (exp_q.size() == 0) begin
          total_cnt++; $display("FAIL rr_extra_beat: got idx %0d want none", a_idx);
        end else begin
          e = exp_q.pop_front();
          total_cnt++; if (a_idx !== 2'(e)) $display("FAIL rr_idx: got %0d want %0d", a_idx, e); else pass_cnt++;
          total_cnt++; if (a_odata !== 32'(32'hA0 + e)) $display("FAIL rr_data: got %h want %h", a_odata, 32'hA0 + e); else pass_cnt++;
          total_cnt++; if (a_ready !== 4'(1 << e)) $display("FAIL rr_ready: got %b want %b", a_ready, 4'(1 << e)); else pass_cnt++;
        end
      end
      @(negedge clk);
    end
    #1;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL rr_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (a_cnt !== 4'd10) $display("FAIL rr_cnt: got %0d want 10", a_cnt); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_hold();
    int e;
    a_valid  = 4'b0101;
    a_oready = 1'b0;
    a_flush  = 1'b1;
    #1;
    total_cnt++; if (a_ovalid !== 1'b0) $display("FAIL hold_flush_valid: got %b want 0", a_ovalid); else pass_cnt++;
    @(negedge clk);
    a_flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++; if (a_idx !== 2'd0) $display("FAIL hold_idx: got %0d want 0", a_idx); else pass_cnt++;
      total_cnt++; if (a_ready !== 4'b0) $display("FAIL hold_ready: got %b want 0000", a_ready); else pass_cnt++;
      if (c == 0) begin
        total_cnt++; if (a_cnt !== 4'd0) $display("FAIL hold_cnt_flushed: got %0d want 0", a_cnt); else pass_cnt++;
      end else begin
        total_cnt++; if (a_busy !== 1'b1) $display("FAIL hold_busy: got %b want 1", a_busy); else pass_cnt++;
      end
      @(negedge clk);
    end
    a_oready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(2);
    for (int k = 0; k < 2; k++) begin
      #1;
      if (a_ovalid && a_oready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total_cnt++; if (a_idx !== 2'(e)) $display("FAIL hold_seq_idx: got %0d want %0d", a_idx, e); else pass_cnt++;
        total_cnt++; if (a_odata !== 32'(32'hA0 + e)) $display("FAIL hold_seq_data: got %h want %h", a_odata, 32'hA0 + e); else pass_cnt++;
      end
      @(negedge clk);
      if (k == 0) a_valid[0] = 1'b0;
    end
    a_valid = 4'h0;
    #1;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL hold_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL hold_idle: got %b want 0", a_busy); else pass_cnt++;
    total_cnt++; if (a_cnt !== 4'd2) $display("FAIL hold_cnt: got %0d want 2", a_cnt); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    // rr_q is 3 here; a lone req2 wins, then all requesters raise valid while the grant is held.
    a_valid  = 4'b0100;
    a_oready = 1'b0;
    #1;
    total_cnt++; if (a_idx !== 2'd2) $display("FAIL flush_pre_idx: got %0d want 2", a_idx); else pass_cnt++;
    @(negedge clk);
    a_valid = 4'hF;
    #1;
    total_cnt++; if (a_idx !== 2'd2) $display("FAIL flush_frozen_idx: got %0d want 2", a_idx); else pass_cnt++;
    total_cnt++; if (a_busy !== 1'b1) $display("FAIL flush_pre_busy: got %b want 1", a_busy); else pass_cnt++;
    a_flush  = 1'b1;
    a_oready = 1'b1;
    #1;
    total_cnt++; if (a_ovalid !== 1'b0) $display("FAIL flush_valid: got %b want 0", a_ovalid); else pass_cnt++;
    total_cnt++; if (a_ready !== 4'b0) $display("FAIL flush_ready: got %b want 0000", a_ready); else pass_cnt++;
    a_oready = 1'b0;
    @(negedge clk);
    a_flush = 1'b0;
    #1;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", a_busy); else pass_cnt++;
    total_cnt++; if (a_cnt !== 4'd0) $display("FAIL flush_cnt: got %0d want 0", a_cnt); else pass_cnt++;
    total_cnt++; if (a_idx !== 2'd0) $display("FAIL flush_rr: got %0d want 0", a_idx); else pass_cnt++;
  endtask

  task automatic test_cnt_wrap();
    int e;
    a_valid  = 4'hF;
    a_oready = 1'b1;
    for (int k = 0; k < 17; k++) exp_q.push_back(k % 4);
    for (int k = 0; k < 17; k++) begin
      #1;
      if (a_ovalid && a_oready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total_cnt++; if (a_idx !== 2'(e)) $display("FAIL wrap_idx: got %0d want %0d", a_idx, e); else pass_cnt++;
      end
      @(negedge clk);
    end
    a_valid  = 4'h0;
    a_oready = 1'b0;
    #1;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (a_cnt !== 4'd1) $display("FAIL wrap_cnt: got %0d want 1", a_cnt); else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_burst();
    int e;
    int beats = 0;
    b_valid  = 4'hF;
    b_oready = 1'b1;
    // req1 withdraws after its first beat, so its burst ends and req2 takes over with no bubble.
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{0, 0, 0, 1, 2, 2, 2, 3, 3, 3};
    for (int k = 0; k < 10; k++) begin
      #1;
      if (b_ovalid && b_oready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        beats++;
        total_cnt++; if (b_idx !== 2'(e)) $display("FAIL burst_idx: got %0d want %0d", b_idx, e); else pass_cnt++;
        total_cnt++; if (b_odata !== 32'(32'hB0 + e)) $display("FAIL burst_data: got %h want %h", b_odata, 32'hB0 + e); else pass_cnt++;
      end
      @(negedge clk);
      if (beats == 4) b_valid[1] = 1'b0;
    end
    b_valid  = 4'h0;
    b_oready = 1'b0;
    #1;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL burst_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (b_cnt !== 16'd10) $display("FAIL burst_cnt: got %0d want 10", b_cnt); else pass_cnt++;
    total_cnt++; if (b_busy !== 1'b0) $display("FAIL burst_idle: got %b want 0", b_busy); else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    b_valid  = 4'hF;
    b_oready = 1'b1;
    @(negedge clk);
    b_oready = 1'b0;
    #1;
    total_cnt++; if (b_busy !== 1'b1) $display("FAIL areset_pre_busy: got %b want 1", b_busy); else pass_cnt++;
    total_cnt++; if (b_cnt !== 16'd11) $display("FAIL areset_pre_cnt: got %0d want 11", b_cnt); else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (b_busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", b_busy); else pass_cnt++;
    total_cnt++; if (b_cnt !== 16'd0) $display("FAIL areset_cnt: got %0d want 0", b_cnt); else pass_cnt++;
    @(negedge clk);
    b_valid = 4'h0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int  e;
    int  n = 0;
    logic took;
    c_valid = 1'b1;
    c_data  = 32'hC00;
    exp_q.push_back(32'hC00);
    for (int k = 0; k < 9; k++) begin
      c_oready = (k % 3 != 0);
      #1;
      took = c_ovalid && c_oready;
      total_cnt++; if (c_idx !== 1'b0) $display("FAIL single_idx: got %0d want 0", c_idx); else pass_cnt++;
      total_cnt++; if (c_ready !== c_oready) $display("FAIL single_ready: got %b want %b", c_ready, c_oready); else pass_cnt++;
      if (took && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n++;
        total_cnt++; if (c_odata !== 32'(e)) $display("FAIL single_data: got %h want %h", c_odata, e); else pass_cnt++;
      end
      @(negedge clk);
      if (took) begin
        c_data = 32'(32'hC00 + n);
        exp_q.push_back(32'hC00 + n);
      end
    end
    c_valid  = 1'b0;
    c_oready = 1'b0;
    #1;
    total_cnt++; if (c_cnt !== 16'd6) $display("FAIL single_cnt: got %0d want 6", c_cnt); else pass_cnt++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_flush();
    test_cnt_wrap();
    test_burst();
    test_async_reset();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
